// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: fetch (i_*) and load/store (d_*).
// master = core side driving requests, slave = arbiter answering them.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        input  i_ack, i_rdata,
        input  d_ack, d_rdata,
        input  err
    );

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        output i_ack, i_rdata,
        output d_ack, d_rdata,
        output err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port program/data RAM.
// Optional MEM_ARB_RR_EN: round-robin on contention instead of d > i.
module mem_arbiter #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data,
    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_oe
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic GNT_I = 1'b0;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic          gnt;
    logic          err_q;
    logic [DW-1:0] wdata_q;

    logic          any_req;
    logic          pick_d;
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic          oor;
    logic          start;
    logic          done_d;
    logic          done_err;

`ifdef MEM_ARB_RR_EN
    logic          last_q;

    // Contention goes to whichever port was not granted last.
    always_comb begin
        pick_d = bus.d_req & (~bus.i_req | (last_q == GNT_I));
    end

    // Pointer follows every grant, contested or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= GNT_I;
        end else if (start) begin
            last_q <= pick_d;
        end
    end
`else
    // Fixed priority: the load/store port wins any contention.
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    assign any_req  = bus.i_req | bus.d_req;
    assign sel_addr = pick_d ? bus.d_addr : bus.i_addr;
    assign sel_we   = pick_d & bus.d_we;
    assign oor      = {1'b0, sel_addr} >= DEPTH_W;
    assign start    = (state == IDLE) & any_req;

    // An out-of-range access jumps from IDLE straight to DONE,
    // before the grant registers are loaded, so use the live pick.
    assign done_d   = (state == IDLE) ? pick_d : gnt;
    assign done_err = (state == IDLE) ? oor : err_q;

    // Next-state sequencing of RAM read/write cycles.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    if (oor) begin
                        nxt = DONE;
                    end else if (sel_we) begin
                        nxt = WR;
                    end else begin
                        nxt = RD_ADDR;
                    end
                end
            end
            RD_ADDR: nxt = RD_DATA;
            RD_DATA: nxt = DONE;
            WR:      nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register and per-operation latches taken at grant time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= GNT_I;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= nxt;
            if (start) begin
                gnt     <= pick_d;
                err_q   <= oor;
                wdata_q <= bus.d_wdata;
            end
        end
    end

    // RAM strobes are registered from the next state so they line up
    // exactly with the state they belong to; cs stays low in IDLE/DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_oe   <= 1'b0;
            ram_addr <= '0;
        end else begin
            ram_cs <= (nxt == RD_ADDR) | (nxt == RD_DATA) | (nxt == WR);
            ram_we <= (nxt == WR);
            ram_oe <= (nxt == RD_DATA);
            if (start && !oor) begin
                ram_addr <= sel_addr;
            end
        end
    end

    // Data bus is only driven while we is high, so we/oe never fight.
    assign ram_data = ram_we ? wdata_q : {DW{1'bz}};

    // Single-cycle ack/err pulses, valid during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            bus.i_ack <= (nxt == DONE) & ~done_d;
            bus.d_ack <= (nxt == DONE) & done_d;
            bus.err   <= (nxt == DONE) & done_err;
        end
    end

    // Read data capture at the end of RD_DATA; out-of-range reads return 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
        end else if (state == RD_DATA) begin
            if (gnt) begin
                bus.d_rdata <= ram_data;
            end else begin
                bus.i_rdata <= ram_data;
            end
        end else if (start && oor) begin
            if (pick_d) begin
                bus.d_rdata <= '0;
            end else begin
                bus.i_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM device model, shadow memory
// reference and per-scenario tasks with randomized traffic.
module tb_mem_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 21;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;

    mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe)
    );

    int checks = 0;
    int errors = 0;

    // RAM device: registers the word while cs & !we, drives it while oe.
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] q = '0;

    assign ram_data = (ram_cs && ram_oe) ? q : {DW{1'bz}};

    always @(posedge clk) begin
        if (pre_we) begin
            if (pre_addr < DEPTH) mem[pre_addr] <= pre_data;
        end else if (ram_cs && ram_we) begin
            if (ram_addr < DEPTH) mem[ram_addr] <= ram_data;
        end else if (ram_cs) begin
            q <= (ram_addr < DEPTH) ? mem[ram_addr] : 32'hBAD0BAD0;
        end
    end

    // Reference model state.
    logic [DW-1:0] shadow [0:DEPTH-1];
    bit last_d = 1'b0;
    int viol = 0;

    // Bus rule watcher and grant-history tracker.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we && ram_oe) viol++;
            if ((ram_we || ram_oe) && !ram_cs) viol++;
            if ((bus.i_ack || bus.d_ack) && ram_cs) viol++;
            if (bus.err && !(bus.i_ack || bus.d_ack)) viol++;
            if (bus.i_ack && bus.d_ack) viol++;
        end
        if (!rst_n) last_d = 1'b0;
        else if (bus.d_ack) last_d = 1'b1;
        else if (bus.i_ack) last_d = 1'b0;
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a >= DEPTH) return '0;
        return shadow[a];
    endfunction

    function automatic int exp_lat(input bit we, input logic [AW-1:0] a);
        if (a >= DEPTH) return 1;
        return we ? 2 : 3;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
        shadow[a] = v;
    endtask

    // One isolated request from idle; returns latency and observations.
    task automatic run_op(input bit is_d, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output int lat, output logic [DW-1:0] rd,
                          output logic e, output int ncs, output int noe,
                          output int oth);
        if (is_d) begin
            bus.d_req = 1'b1;
            bus.d_we = we;
            bus.d_addr = a;
            bus.d_wdata = wd;
        end else begin
            bus.i_req = 1'b1;
            bus.i_addr = a;
        end
        lat = -1; rd = '0; e = 1'b0; ncs = 0; noe = 0; oth = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ram_cs) ncs++;
            if (ram_oe) noe++;
            if (is_d ? bus.i_ack : bus.d_ack) oth++;
            if (is_d ? bus.d_ack : bus.i_ack) begin
                lat = c;
                rd = is_d ? bus.d_rdata : bus.i_rdata;
                e = bus.err;
                break;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int a = 0; a < DEPTH; a++) preload(AW'(a), $urandom);
        @(posedge clk); #1;
        checks++;
        if ({bus.i_ack, bus.d_ack, bus.err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_acks got %b want 000", {bus.i_ack, bus.d_ack, bus.err});
        end
        checks++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ram_ctl got %b want 000", {ram_cs, ram_we, ram_oe});
        end
        checks++;
        if (ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_ram_addr got %h want 0", ram_addr);
        end
        checks++;
        if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h want 0/0", bus.i_rdata, bus.d_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        int lat, ncs, noe, oth;
        logic [DW-1:0] rd;
        logic e;
        preload(5, 32'hDEADBEEF);
        run_op(1'b0, 1'b0, 5, '0, lat, rd, e, ncs, noe, oth);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL fetch_lat got %0d want 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data got %h want deadbeef", rd); end
        checks++;
        if (ncs !== 2 || noe !== 1) begin
            errors++;
            $display("FAIL fetch_strobes got cs=%0d oe=%0d want cs=2 oe=1", ncs, noe);
        end
    endtask

    task automatic test_store_load();
        int lat, ncs, noe, oth;
        logic [DW-1:0] rd;
        logic e;
        run_op(1'b1, 1'b1, 3, 32'h12345678, lat, rd, e, ncs, noe, oth);
        shadow[3] = 32'h12345678;
        checks++;
        if (lat !== 2 || ncs !== 1 || noe !== 0) begin
            errors++;
            $display("FAIL store_lat got lat=%0d cs=%0d oe=%0d want 2/1/0", lat, ncs, noe);
        end
        run_op(1'b1, 1'b0, 3, '0, lat, rd, e, ncs, noe, oth);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL load_lat got %0d want 3", lat); end
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL load_data got %h want 12345678", rd); end
    endtask

    task automatic test_out_of_range();
        int lat, ncs, noe, oth;
        logic [DW-1:0] rd;
        logic e;
        run_op(1'b1, 1'b0, 21, '0, lat, rd, e, ncs, noe, oth);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin
            errors++;
            $display("FAIL oor_ack got lat=%0d err=%b want 1/1", lat, e);
        end
        checks++;
        if (rd !== '0) begin errors++; $display("FAIL oor_rdata got %h want 0", rd); end
        checks++;
        if (ncs !== 0) begin errors++; $display("FAIL oor_cs got %0d want 0", ncs); end
    endtask

    task automatic test_reset_mid();
        int lat, ncs, noe, oth, acks;
        logic [DW-1:0] rd;
        logic e;
        bus.i_req = 1'b1;
        bus.i_addr = 4;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.i_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_ctl got %b want 000", {ram_cs, ram_we, ram_oe});
        end
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.i_ack || bus.d_ack) acks++;
            @(posedge clk); #1;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL midrst_noack got %0d want 0", acks); end
        run_op(1'b0, 1'b0, 0, '0, lat, rd, e, ncs, noe, oth);
        checks++;
        if (lat !== 3 || rd !== shadow[0]) begin
            errors++;
            $display("FAIL midrst_fetch got lat=%0d %h want 3 %h", lat, rd, shadow[0]);
        end
    endtask

    task automatic test_contention();
        int n;
        bit got, exp;
        n = 0;
        bus.i_addr = 1;
        bus.d_addr = 2;
        bus.d_we = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(posedge clk); #1;
            if (bus.i_ack || bus.d_ack) begin
                got = bus.d_ack;
                exp = RR ? ~last_d : 1'b1;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL contend_grant%0d got d=%b want d=%b", n, got, exp);
                end
                checks++;
                if ((got ? bus.d_rdata : bus.i_rdata) !== shadow[got ? 2 : 1]) begin
                    errors++;
                    $display("FAIL contend_data%0d got %h want %h", n,
                             got ? bus.d_rdata : bus.i_rdata, shadow[got ? 2 : 1]);
                end
                n++;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL contend_count got %0d want 4", n); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int idx, prev;
        idx = 0;
        prev = 0;
        bus.i_addr = 0;
        bus.i_req = 1'b1;
        for (int c = 1; c <= 40 && idx < 3; c++) begin
            @(posedge clk); #1;
            if (bus.i_ack) begin
                checks++;
                if (bus.i_rdata !== shadow[idx]) begin
                    errors++;
                    $display("FAIL b2b_data%0d got %h want %h", idx, bus.i_rdata, shadow[idx]);
                end
                checks++;
                if (c - prev !== (idx == 0 ? 3 : 4)) begin
                    errors++;
                    $display("FAIL b2b_gap%0d got %0d want %0d", idx, c - prev, idx == 0 ? 3 : 4);
                end
                prev = c;
                idx++;
                if (idx < 3) bus.i_addr = AW'(idx);
            end
        end
        bus.i_req = 1'b0;
        checks++;
        if (idx !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, ncs, noe, oth;
        logic [DW-1:0] rd, wd, expv;
        logic e;
        logic [AW-1:0] a;
        bit is_d, we;
        for (int k = 0; k < 40; k++) begin
            is_d = 1'($urandom_range(0, 1));
            we = is_d & 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 25));
            wd = $urandom;
            expv = exp_rd(a);
            run_op(is_d, we, a, wd, lat, rd, e, ncs, noe, oth);
            checks++;
            if (lat !== exp_lat(we, a)) begin
                errors++;
                $display("FAIL rnd_lat%0d got %0d want %0d", k, lat, exp_lat(we, a));
            end
            checks++;
            if (e !== (a >= DEPTH)) begin
                errors++;
                $display("FAIL rnd_err%0d got %b want %b", k, e, a >= DEPTH);
            end
            if (!we) begin
                checks++;
                if (rd !== expv) begin
                    errors++;
                    $display("FAIL rnd_data%0d got %h want %h", k, rd, expv);
                end
            end else if (a < DEPTH) begin
                shadow[a] = wd;
            end
            checks++;
            if (oth !== 0) begin errors++; $display("FAIL rnd_stray%0d got %0d want 0", k, oth); end
        end
    endtask

    task automatic test_rand_contention();
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dwd;
        bit dwe, exp_first;
        int first, second;
        for (int k = 0; k < 12; k++) begin
            ia = AW'($urandom_range(0, 22));
            da = AW'($urandom_range(0, 22));
            dwe = 1'($urandom_range(0, 1));
            dwd = $urandom;
            exp_first = RR ? ~last_d : 1'b1;
            bus.i_addr = ia;
            bus.d_addr = da;
            bus.d_we = dwe;
            bus.d_wdata = dwd;
            bus.i_req = 1'b1;
            bus.d_req = 1'b1;
            first = -1;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (bus.i_ack || bus.d_ack) begin
                    first = bus.d_ack ? 1 : 0;
                    break;
                end
            end
            checks++;
            if (first !== int'(exp_first)) begin
                errors++;
                $display("FAIL rc_first%0d got %0d want %0d", k, first, exp_first);
            end
            if (first == 1) begin
                checks++;
                if (bus.err !== (da >= DEPTH) || (!dwe && bus.d_rdata !== exp_rd(da))) begin
                    errors++;
                    $display("FAIL rc_d%0d got %h err=%b want %h", k, bus.d_rdata, bus.err, exp_rd(da));
                end
                if (dwe && da < DEPTH) shadow[da] = dwd;
                bus.d_req = 1'b0;
            end else if (first == 0) begin
                checks++;
                if (bus.err !== (ia >= DEPTH) || bus.i_rdata !== exp_rd(ia)) begin
                    errors++;
                    $display("FAIL rc_i%0d got %h err=%b want %h", k, bus.i_rdata, bus.err, exp_rd(ia));
                end
                bus.i_req = 1'b0;
            end
            second = -1;
            if (first >= 0) begin
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk); #1;
                    if (bus.i_ack || bus.d_ack) begin
                        second = bus.d_ack ? 1 : 0;
                        break;
                    end
                end
            end
            checks++;
            if (first < 0 || second !== 1 - first) begin
                errors++;
                $display("FAIL rc_second%0d got %0d want %0d", k, second, 1 - first);
            end else if (second == 1) begin
                checks++;
                if (bus.err !== (da >= DEPTH) || (!dwe && bus.d_rdata !== exp_rd(da))) begin
                    errors++;
                    $display("FAIL rc_d2_%0d got %h err=%b want %h", k, bus.d_rdata, bus.err, exp_rd(da));
                end
                if (dwe && da < DEPTH) shadow[da] = dwd;
            end else begin
                checks++;
                if (bus.err !== (ia >= DEPTH) || bus.i_rdata !== exp_rd(ia)) begin
                    errors++;
                    $display("FAIL rc_i2_%0d got %h err=%b want %h", k, bus.i_rdata, bus.err, exp_rd(ia));
                end
            end
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bus_rules();
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL bus_rules got %0d violations want 0", viol); end
    endtask

    initial begin
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_fetch();
        test_store_load();
        test_out_of_range();
        test_reset_mid();
        test_contention();
        test_back_to_back();
        test_random();
        test_rand_contention();
        test_bus_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
